// File: rtl/lib_arb_rr.sv
// Request arbiter with a locked grant: fixed priority (MODE=0) or round-robin (MODE=1).
// A grant is held until ack; on ack the next winner loads at the same edge.
module lib_arb_rr #(
  parameter int WIDTH = 4,
  parameter int MODE  = 1,
  parameter int IDW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] req,
  input  logic             ack,
  output logic [WIDTH-1:0] gnt,
  output logic             gnt_vld,
  output logic [IDW-1:0]   gnt_id
);

  // Handshake: the holder of gnt raises ack for one cycle to release it;
  // ack is only meaningful while gnt_vld=1 and is ignored otherwise.

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t           state;
  logic [WIDTH-1:0] base;
  logic [IDW-1:0]   base_idx;
  logic [IDW-1:0]   rot_idx;
  logic [IDW-1:0]   start_idx;
  logic [IDW-1:0]   win_idx;
  logic [IDW-1:0]   pos;
  logic [IDW:0]     sum;
  logic             win_found;

  always_comb begin
    base_idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (base[i]) base_idx = base_idx | IDW'(i);
    end
  end

  // Pointer value the holder leaves behind once it acks: one past itself.
  always_comb begin
    if (int'(gnt_id) == WIDTH - 1) rot_idx = '0;
    else                           rot_idx = gnt_id + IDW'(1);
  end

  // In BUSY the search must already use the post-ack pointer so that a
  // back-to-back grant sees the updated priority.
  always_comb begin
    if (state == BUSY) start_idx = (MODE == 1) ? rot_idx : '0;
    else               start_idx = base_idx;
  end

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    sum       = '0;
    pos       = '0;
    for (int i = 0; i < WIDTH; i++) begin
      sum = {1'b0, start_idx} + (IDW+1)'(i);
      if (sum >= (IDW+1)'(WIDTH)) sum = sum - (IDW+1)'(WIDTH);
      pos = sum[IDW-1:0];
      if (!win_found && req[pos]) begin
        win_found = 1'b1;
        win_idx   = pos;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      base    <= WIDTH'(1);
      gnt     <= '0;
      gnt_vld <= 1'b0;
      gnt_id  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (win_found) begin
            state   <= BUSY;
            gnt     <= WIDTH'(1) << win_idx;
            gnt_id  <= win_idx;
            gnt_vld <= 1'b1;
          end
        end
        BUSY: begin
          if (ack) begin
            if (MODE == 1) base <= WIDTH'(1) << rot_idx;
            if (win_found) begin
              gnt     <= WIDTH'(1) << win_idx;
              gnt_id  <= win_idx;
              gnt_vld <= 1'b1;
            end else begin
              state   <= IDLE;
              gnt     <= '0;
              gnt_id  <= '0;
              gnt_vld <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
